fifo_skew_sched: RTL and testbench

- Sequences the reads of the per-row activation FIFOs that feed the systolic array.
- Applies the diagonal skew: row i begins reading i cycles after row 0, and every row reads `len` entries per tile.
- If any FIFO required in a given cycle is empty, all rows stall together so the wavefront stays aligned.
- Sits between the tile controller (`start`/`len`/`done`) and the `we`/`re`/`empty` interface of the row FIFOs.

---
 rtl/fifo_skew_sched_if.sv | 25 ++
 rtl/fifo_skew_sched.sv | 84 ++++++++
 tb/tb_fifo_skew_sched.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_skew_sched_if.sv
// Handshake bundle between the tile controller, the row FIFOs and the skew scheduler.
// The master side drives tile requests and FIFO empty flags; the slave side is the scheduler.
interface fifo_skew_sched_if #(
  parameter int ROWS      = 4,
  parameter int LEN_WIDTH = 8
);
  logic                 start;
  logic [LEN_WIDTH-1:0] len;
  logic [ROWS-1:0]      fifo_empty;
  logic [ROWS-1:0]      fifo_re;
  logic [ROWS-1:0]      row_valid;
  logic                 stall;
  logic                 busy;
  logic                 done;

  modport master (
    output start, len, fifo_empty,
    input  fifo_re, row_valid, stall, busy, done
  );

  modport slave (
    input  start, len, fifo_empty,
    output fifo_re, row_valid, stall, busy, done
  );
endinterface

// File: rtl/fifo_skew_sched.sv
// Diagonal-skew read scheduler for the per-row activation FIFOs of the systolic array.
// Row i reads len entries starting i steps after row 0; any blocked read stalls every row.
module fifo_skew_sched #(
  parameter int ROWS      = 4,
  parameter int LEN_WIDTH = 8
) (
  input logic              clk,
  input logic              rst,
  fifo_skew_sched_if.slave bus
);
  localparam int CW = LEN_WIDTH + $clog2(ROWS) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        t_q, t_d;
  logic [CW-1:0]        last_t;
  logic [LEN_WIDTH-1:0] l_q, l_d;
  logic [ROWS-1:0]      active;
  logic [ROWS-1:0]      re;
  logic [ROWS-1:0]      rv_q;
  logic                 stall_c;

  // Final step index of the wavefront; L >= 1 in RUN, so this never underflows.
  assign last_t = CW'(l_q) + CW'(ROWS) - CW'(2);

  always_comb begin
    active = '0;
    for (int unsigned i = 0; i < ROWS; i++) begin
      active[i] = (t_q >= CW'(i)) && (t_q < CW'(i) + CW'(l_q));
    end
  end

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    l_d     = l_q;
    re      = '0;
    stall_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.len != '0) begin
            l_d     = bus.len;
            t_d     = '0;
            state_d = RUN;
          end else begin
            state_d = DRAIN;
          end
        end
      end
      RUN: begin
        stall_c = |(active & bus.fifo_empty);
        if (!stall_c) begin
          re  = active;
          t_d = t_q + CW'(1);
          if (t_q == last_t) state_d = DRAIN;
        end
      end
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      t_q     <= '0;
      l_q     <= '0;
      rv_q    <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      l_q     <= l_d;
      rv_q    <= re;
    end
  end

  assign bus.fifo_re   = re;
  assign bus.row_valid = rv_q;
  assign bus.stall     = stall_c;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DRAIN);
endmodule

// File: tb/tb_fifo_skew_sched.sv
// Bench for fifo_skew_sched: directed vector tables, corner sequences and a randomized run
// checked against a per-row read-count model of the skewed wavefront.
module tb_fifo_skew_sched;
  localparam int ROWS = 4;
  localparam int LW   = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_skew_sched_if #(.ROWS(ROWS), .LEN_WIDTH(LW)) bus ();
  fifo_skew_sched #(.ROWS(ROWS), .LEN_WIDTH(LW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  // Model: mode 0 idle / 1 run / 2 drain; steps = unstalled run cycles; cnt = reads per row.
  int              m_mode, m_steps, m_L;
  int              m_cnt[ROWS];
  logic [ROWS-1:0] m_prev_re;

  logic [ROWS-1:0] s_re, s_rv;
  logic            s_stall, s_busy, s_done;

  typedef struct {
    logic            start;
    logic [LW-1:0]   len;
    logic [ROWS-1:0] empty;
    logic [ROWS-1:0] re;
    logic [ROWS-1:0] rv;
    logic            stall;
    logic            busy;
    logic            done;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_steps = 0; m_L = 0; m_prev_re = '0;
    foreach (m_cnt[i]) m_cnt[i] = 0;
  endtask

  // One clock cycle: inputs are already set; sample, compare with model, advance.
  task automatic step();
    logic [ROWS-1:0] act, e_re;
    logic            e_stall;
    #1;
    s_re = bus.fifo_re; s_rv = bus.row_valid; s_stall = bus.stall;
    s_busy = bus.busy; s_done = bus.done;
    act = '0; e_re = '0; e_stall = 1'b0;
    if (m_mode == 1) begin
      for (int i = 0; i < ROWS; i++) begin
        act[i] = (m_steps >= i) && (m_cnt[i] < m_L);
        if (act[i] && bus.fifo_empty[i]) e_stall = 1'b1;
      end
      if (!e_stall) e_re = act;
    end
    chk("m_fifo_re", s_re, e_re);
    chk("m_row_valid", s_rv, m_prev_re);
    chk("m_stall", s_stall, e_stall);
    chk("m_busy", s_busy, m_mode != 0);
    chk("m_done", s_done, m_mode == 2);
    if (rst) begin
      model_reset();
    end else begin
      m_prev_re = e_re;
      case (m_mode)
        0: if (bus.start) begin
             if (bus.len != 0) begin
               m_mode = 1; m_L = bus.len; m_steps = 0;
               foreach (m_cnt[i]) m_cnt[i] = 0;
             end else begin
               m_mode = 2;
             end
           end
        1: if (!e_stall) begin
             for (int i = 0; i < ROWS; i++) m_cnt[i] += int'(e_re[i]);
             m_steps++;
             if (m_cnt[ROWS-1] == m_L) m_mode = 2;
           end
        default: m_mode = 0;
      endcase
    end
    @(posedge clk);
    #2;
  endtask

  task automatic set_in(input logic st, input logic [LW-1:0] ln, input logic [ROWS-1:0] em);
    bus.start = st; bus.len = ln; bus.fifo_empty = em;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int rd[ROWS];
    int first_done, second_re, dones, c;
    logic found;

    rst = 1'b1;
    set_in(1'b0, '0, '0);
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;

    step();
    chk("rst_fifo_re", s_re, 0);
    chk("rst_row_valid", s_rv, 0);
    chk("rst_busy", s_busy, 0);
    chk("rst_done", s_done, 0);
    chk("rst_stall", s_stall, 0);

    // Basic skew, len=3
    tbl.push_back('{1'b1, 8'd3, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 8'd0, 4'b0000, 4'b0001, 4'b0000, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 8'd0, 4'b0000, 4'b0011, 4'b0001, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 8'd0, 4'b0000, 4'b0111, 4'b0011, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 8'd0, 4'b0000, 4'b1110, 4'b0111, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 8'd0, 4'b0000, 4'b1100, 4'b1110, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 8'd0, 4'b0000, 4'b1000, 4'b1100, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 8'd0, 4'b0000, 4'b0000, 4'b1000, 1'b0, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 8'd0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0});
    // Stall on row 2 during cycle 3 (entries 9..18)
    tbl.push_back('{1'b1, 8'd3, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 8'd0, 4'b0000, 4'b0001, 4'b0000, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 8'd0, 4'b0000, 4'b0011, 4'b0001, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 8'd0, 4'b0100, 4'b0000, 4'b0011, 1'b1, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 8'd0, 4'b0000, 4'b0111, 4'b0000, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 8'd0, 4'b0000, 4'b1110, 4'b0111, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 8'd0, 4'b0000, 4'b1100, 4'b1110, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 8'd0, 4'b0000, 4'b1000, 4'b1100, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 8'd0, 4'b0000, 4'b0000, 4'b1000, 1'b0, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 8'd0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0});
    // Row 3 empty while still inactive: no stall
    tbl.push_back('{1'b1, 8'd3, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 8'd0, 4'b1000, 4'b0001, 4'b0000, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 8'd0, 4'b1000, 4'b0011, 4'b0001, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 8'd0, 4'b1000, 4'b0111, 4'b0011, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 8'd0, 4'b0000, 4'b1110, 4'b0111, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 8'd0, 4'b0000, 4'b1100, 4'b1110, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 8'd0, 4'b0000, 4'b1000, 4'b1100, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 8'd0, 4'b0000, 4'b0000, 4'b1000, 1'b0, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 8'd0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0});

    foreach (rd[i]) rd[i] = 0;
    foreach (tbl[k]) begin
      set_in(tbl[k].start, tbl[k].len, tbl[k].empty);
      step();
      chk("tbl_fifo_re", s_re, tbl[k].re);
      chk("tbl_row_valid", s_rv, tbl[k].rv);
      chk("tbl_stall", s_stall, tbl[k].stall);
      chk("tbl_busy", s_busy, tbl[k].busy);
      chk("tbl_done", s_done, tbl[k].done);
      if (k >= 9 && k <= 18)
        for (int i = 0; i < ROWS; i++) rd[i] += int'(s_re[i]);
    end
    for (int i = 0; i < ROWS; i++) chk("stall_reads_per_row", rd[i], 3);

    // Reset in the middle of a tile, then restart
    set_in(1'b1, 8'd5, '0); step();
    set_in(1'b0, '0, '0);
    repeat (3) step();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    step();
    chk("midrst_fifo_re", s_re, 0);
    chk("midrst_row_valid", s_rv, 0);
    chk("midrst_busy", s_busy, 0);
    chk("midrst_done", s_done, 0);
    set_in(1'b1, 8'd2, '0); step();
    set_in(1'b0, '0, '0); step();
    chk("midrst_restart_re", s_re, 4'b0001);
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      step();
      found = s_done;
    end
    chk("midrst_restart_done", found, 1);
    step();

    // len = 0: done one cycle after start, no reads
    set_in(1'b1, 8'd0, '0); step();
    set_in(1'b0, '0, '0); step();
    chk("len0_done", s_done, 1);
    chk("len0_fifo_re", s_re, 0);
    chk("len0_busy", s_busy, 1);
    step();
    chk("len0_idle", s_busy, 0);

    // start pulses while busy are ignored
    set_in(1'b1, 8'd5, '0); step();
    dones = 0;
    for (c = 1; c <= 16; c++) begin
      set_in((c >= 2 && c <= 7) ? 1'($urandom_range(0, 1)) : 1'b0, LW'($urandom_range(0, 255)), '0);
      step();
      if (s_done) dones++;
    end
    chk("busy_start_dones", dones, 1);

    // Back-to-back maximum-length tiles with start held
    set_in(1'b1, 8'd255, '0);
    first_done = -1; second_re = -1;
    foreach (rd[i]) rd[i] = 0;
    for (c = 0; c < 270; c++) begin
      step();
      if (first_done < 0) for (int i = 0; i < ROWS; i++) rd[i] += int'(s_re[i]);
      if (s_done && first_done < 0) first_done = c;
      if (first_done >= 0 && c > first_done && s_re[0] && second_re < 0) second_re = c;
    end
    chk("b2b_first_done", first_done, 259);
    chk("b2b_second_re0", second_re, 261);
    for (int i = 0; i < ROWS; i++) chk("b2b_reads_per_row", rd[i], 255);
    set_in(1'b0, '0, '0);
    for (int n = 0; n < 400 && s_busy; n++) step();
    chk("b2b_drain_timeout", s_busy, 0);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic [ROWS-1:0] em;
      for (int i = 0; i < ROWS; i++) em[i] = ($urandom_range(0, 4) == 0);
      rst = ($urandom_range(0, 199) == 0);
      set_in($urandom_range(0, 3) == 0, LW'($urandom_range(0, 12)), em);
      step();
    end
    rst = 1'b0;
    set_in(1'b0, '0, '0);
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
